// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter and
// any future scheduler that reuses its picker.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Width of a beat counter able to hold 0..max_burst-1, never narrower than 1 bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle of the write arbiter: requests, burst flags and data
// in, FIFO write strobe and data out, plus grant status.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) ();

  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             last;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
  logic                           f_full;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             accept;
  logic                           w_en;
  logic [DATA_W-1:0]              d_out;
  logic [OWN_W-1:0]               owner;
  logic                           busy;

  // Producers and the FIFO full flag drive this side.
  modport master (
    output req, last, wdata, f_full,
    input  gnt, accept, w_en, d_out, owner, busy
  );

  // The arbiter itself.
  modport slave (
    input  req, last, wdata, f_full,
    output gnt, accept, w_en, d_out, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority selector: returns the first asserted request at or
// above rr_ptr, wrapping past the top index back to zero.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// A winner holds the port for up to MAX_BURST beats or until its last beat;
// one idle cycle always separates consecutive bursts.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic         w_clk,
  input  logic         wrst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [OWN_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] accept_c;
  logic               w_en_c;
  logic [DATA_W-1:0]  d_out_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Beat acceptance and the write path follow the registered grant with no added latency.
  always_comb begin
    accept_c = gnt_q & bus.req & {NUM_REQ{~bus.f_full}};
    w_en_c   = |accept_c;
    d_out_c  = '0;
    if (state_q == ARB_BURST) begin
      d_out_c = bus.wdata[owner_q];
    end
  end

  // Next-state logic: grant on any request in IDLE, release on last beat or burst cap.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d        = ARB_BURST;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          cnt_d          = '0;
          if (winner == OWN_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = winner + 1'b1;
          end
        end
      end
      ARB_BURST: begin
        // A stalled beat (req low or FIFO full) leaves grant, count and last untouched.
        if (w_en_c) begin
          if (bus.last[owner_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ARB_BURST);
  end

  // Arbiter state register; reset abandons any partial burst and restarts priority at 0.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.accept = accept_c;
  assign bus.w_en   = w_en_c;
  assign bus.d_out  = d_out_c;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;

endmodule
